flexdpe_feeder: RTL

// - Upstream sequencer that drives the FLEX-DPE input interface:

---
 rtl/flexdpe_feeder_pkg.sv | 22 ++
 rtl/flexdpe_feeder_if.sv | 31 +++
 rtl/flexdpe_feeder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/flexdpe_feeder_pkg.sv
// Shared definitions for the FLEX-DPE input feeder: default geometry,
// FSM state encoding and a small sizing helper.
package flexdpe_feeder_pkg;

    localparam int unsigned DEF_IN_DATA_TYPE = 16;
    localparam int unsigned DEF_NUM_PES      = 32;
    localparam int unsigned DEF_LOG2_PES     = 5;
    localparam int unsigned DEF_DRAIN_LAT    = 12;
    localparam int unsigned DEF_CNT_W        = 16;

    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_DRAIN  = 2'd2
    } feed_state_e;

    // Width of a down-counter that must hold lat-1.
    function automatic int unsigned drain_cnt_w(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/flexdpe_feeder_if.sv
// Upstream tile stream into the feeder: ready/valid handshake plus the
// per-beat payload, xbar destinations, VN separator and framing flags.
interface flexdpe_feeder_if
    import flexdpe_feeder_pkg::*;
#(
    parameter int unsigned IN_DATA_TYPE = DEF_IN_DATA_TYPE,
    parameter int unsigned NUM_PES      = DEF_NUM_PES,
    parameter int unsigned LOG2_PES     = DEF_LOG2_PES
) ();

    logic                             s_valid;
    logic                             s_ready;
    logic [NUM_PES*IN_DATA_TYPE-1:0]  s_data;
    logic [NUM_PES*LOG2_PES-1:0]      s_dest;
    logic [NUM_PES*LOG2_PES-1:0]      s_vn;
    logic                             s_stationary;
    logic                             s_last;

    // Tile producer.
    modport master (
        output s_valid, s_data, s_dest, s_vn, s_stationary, s_last,
        input  s_ready
    );

    // Feeder side.
    modport slave (
        input  s_valid, s_data, s_dest, s_vn, s_stationary, s_last,
        output s_ready
    );

endinterface

// File: rtl/flexdpe_feeder.sv
// Sequencer in front of the FLEX-DPE: accepts a header beat then streaming
// beats per tile, drives the registered DPE input bus, holds the VN separator
// for the whole tile and stalls the next tile until the pipeline has drained.
module flexdpe_feeder
    import flexdpe_feeder_pkg::*;
#(
    parameter int unsigned IN_DATA_TYPE = DEF_IN_DATA_TYPE,
    parameter int unsigned NUM_PES      = DEF_NUM_PES,
    parameter int unsigned LOG2_PES     = DEF_LOG2_PES,
    parameter int unsigned DRAIN_LAT    = DEF_DRAIN_LAT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                            CLK,
    input  logic                            rst,
    flexdpe_feeder_if.slave                 s,
    output logic                            o_data_valid,
    output logic [NUM_PES*IN_DATA_TYPE-1:0] o_data_bus,
    output logic                            o_stationary,
    output logic [NUM_PES*LOG2_PES-1:0]     o_dest_bus,
    output logic [NUM_PES*LOG2_PES-1:0]     o_vn_seperator,
    output logic                            o_busy,
    output logic                            o_tile_done,
    output logic [CNT_W-1:0]                o_beat_cnt,
    output logic                            o_err
);

    localparam int unsigned         DCNT_W        = drain_cnt_w(DRAIN_LAT);
    localparam logic [DCNT_W-1:0]   DRAIN_LOAD    = DCNT_W'(DRAIN_LAT - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX       = '1;
    // With a one-cycle drain the done pulse must already fire on entry.
    localparam logic                DONE_ON_ENTRY = (DRAIN_LAT == 1);

    feed_state_e        state;
    logic [DCNT_W-1:0]  drain_cnt;
    logic               accept;

    // Ready is a pure function of state so upstream can never form a loop.
    assign s.s_ready = (state != FEED_DRAIN);
    assign accept    = s.s_valid & s.s_ready;
    assign o_busy    = (state != FEED_IDLE);

    // FSM, drain/beat counters and all registered DPE-facing outputs.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state          <= FEED_IDLE;
            drain_cnt      <= '0;
            o_data_valid   <= 1'b0;
            o_data_bus     <= '0;
            o_stationary   <= 1'b0;
            o_dest_bus     <= '0;
            o_vn_seperator <= '0;
            o_tile_done    <= 1'b0;
            o_beat_cnt     <= '0;
            o_err          <= 1'b0;
        end else begin
            // Pulses and qualifiers default low; buses hold.
            o_data_valid <= 1'b0;
            o_stationary <= 1'b0;
            o_tile_done  <= 1'b0;

            case (state)
                FEED_IDLE: begin
                    if (accept) begin
                        if (s.s_stationary) begin
                            o_data_valid   <= 1'b1;
                            o_stationary   <= 1'b1;
                            o_data_bus     <= s.s_data;
                            o_dest_bus     <= s.s_dest;
                            o_vn_seperator <= s.s_vn;
                            o_beat_cnt     <= '0;
                            if (s.s_last) begin
                                state       <= FEED_DRAIN;
                                drain_cnt   <= DRAIN_LOAD;
                                o_tile_done <= DONE_ON_ENTRY;
                            end else begin
                                state <= FEED_STREAM;
                            end
                        end else begin
                            // Streaming beat without a header: drop it.
                            o_err <= 1'b1;
                        end
                    end
                end

                FEED_STREAM: begin
                    if (accept) begin
                        if (!s.s_stationary) begin
                            o_data_valid <= 1'b1;
                            o_data_bus   <= s.s_data;
                            o_dest_bus   <= s.s_dest;
                            if (o_beat_cnt != CNT_MAX) begin
                                o_beat_cnt <= o_beat_cnt + CNT_W'(1);
                            end
                            if (s.s_last) begin
                                state       <= FEED_DRAIN;
                                drain_cnt   <= DRAIN_LOAD;
                                o_tile_done <= DONE_ON_ENTRY;
                            end
                        end else begin
                            // Second header inside a tile: drop, keep VN.
                            o_err <= 1'b1;
                        end
                    end
                end

                FEED_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= FEED_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                        // Registered one early so the pulse lands in the last drain cycle.
                        if (drain_cnt == DCNT_W'(1)) begin
                            o_tile_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= FEED_IDLE;
                end
            endcase
        end
    end

endmodule
